internal_framebuffer_stream_reader: RTL and testbench

Read port for the on-chip framebuffer with full back-pressure on both channels. It accepts pixel addresses on an `ar` stream and issues line reads to a synchronous RAM with a configurable read latency. It extracts the addressed pixel from the returned line and delivers it on an `r` stream through a credit-protected output FIFO. It sits between the fragment/stream pipeline and the framebuffer RAM, and replaces the fixed-latency, non-stallable reader.

---
 rtl/internal_framebuffer_stream_reader.sv | 128 ++++++++++++
 tb/tb_internal_framebuffer_stream_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/internal_framebuffer_stream_reader.sv
// Framebuffer read port: ar stream -> synchronous line RAM -> lane extract -> FWFT FIFO -> r stream.
// Credits are reserved at address accept, so returning RAM data always has a FIFO slot.
module internal_framebuffer_stream_reader #(
    parameter int unsigned NUMBER_OF_PIXELS_PER_BEAT    = 1,
    parameter int unsigned NUMBER_OF_SUB_PIXELS         = 4,
    parameter int unsigned SUB_PIXEL_WIDTH              = 8,
    parameter int unsigned FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int unsigned MEM_READ_LATENCY             = 1,
    parameter int unsigned FIFO_DEPTH                   = 4,
    localparam int unsigned ADDR_WIDTH     = FRAMEBUFFER_SIZE_IN_PIXEL_LG,
    localparam int unsigned PIXEL_WIDTH    = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int unsigned MEM_WIDTH      = PIXEL_WIDTH * NUMBER_OF_PIXELS_PER_BEAT,
    localparam int unsigned LANE_LG        = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
    localparam int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH - LANE_LG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic                      arlast,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      rlast,
    output logic [PIXEL_WIDTH-1:0]    rdata,
    input  logic [MEM_WIDTH-1:0]      readDataPort,
    output logic [MEM_ADDR_WIDTH-1:0] readAddrPort,
    output logic                      readEnablePort
);

    localparam int unsigned LANE_W  = (LANE_LG == 0) ? 1 : LANE_LG;
    localparam int unsigned FIFO_LG = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_LG + 1;
    localparam int unsigned LAT     = MEM_READ_LATENCY;

    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LAT-1:0]         pipe_valid_q, pipe_valid_d;
    logic [LAT-1:0]         pipe_last_q, pipe_last_d;
    logic [LANE_W-1:0]      pipe_lane_q [LAT];
    logic [LANE_W-1:0]      pipe_lane_d [LAT];
    logic [PIXEL_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PIXEL_WIDTH:0]   fifo_head;
    logic [PIXEL_WIDTH-1:0] push_pixel;
    logic [LANE_W-1:0]      ar_lane;
    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   fifo_empty;
    logic                   fifo_full;

    generate
        if (LANE_LG == 0) begin : g_single_lane
            assign ar_lane = '0;
        end else begin : g_multi_lane
            assign ar_lane = araddr[LANE_LG-1:0];
        end
    endgenerate

    // arready depends only on the credit register and reset, never on rready
    assign arready        = !reset && (pending_q < CNT_W'(FIFO_DEPTH));
    assign accept         = arvalid && arready;
    assign readEnablePort = accept;
    assign readAddrPort   = araddr[ADDR_WIDTH-1:LANE_LG];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem_q[rd_ptr_q[FIFO_LG-1:0]];
    assign rvalid     = !fifo_empty;
    assign rdata      = rvalid ? fifo_head[PIXEL_WIDTH-1:0] : '0;
    assign rlast      = rvalid && fifo_head[PIXEL_WIDTH];
    assign pop        = rvalid && rready;
    assign push       = pipe_valid_q[LAT-1];

    always_comb begin
        pending_d = pending_q;
        case ({accept, pop})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase

        wr_ptr_d = wr_ptr_q + CNT_W'(push);
        rd_ptr_d = rd_ptr_q + CNT_W'(pop);

        pipe_valid_d[0] = accept;
        pipe_last_d[0]  = arlast;
        pipe_lane_d[0]  = ar_lane;
        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_last_d[i]  = pipe_last_q[i-1];
            pipe_lane_d[i]  = pipe_lane_q[i-1];
        end

        push_pixel = '0;
        for (int unsigned i = 0; i < NUMBER_OF_PIXELS_PER_BEAT; i++) begin
            if (pipe_lane_q[LAT-1] == LANE_W'(i)) begin
                push_pixel = readDataPort[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pipe_valid_q <= '0;
        end else begin
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        pipe_last_q <= pipe_last_d;
        pipe_lane_q <= pipe_lane_d;
        if (push) begin
            fifo_mem_q[wr_ptr_q[FIFO_LG-1:0]] <= {pipe_last_q[LAT-1], push_pixel};
        end
    end

    fifo_overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_internal_framebuffer_stream_reader.sv
// Randomized scoreboard bench for internal_framebuffer_stream_reader: default build, 4-lane build
// and a latency-3/depth-8 build share one clock and reset.
module tb_internal_framebuffer_stream_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_c[$];

    // instance A: defaults
    logic a_arvalid = 1'b0, a_arlast = 1'b0, a_rready = 1'b0;
    logic [17:0] a_araddr = '0;
    logic a_arready, a_rvalid, a_rlast, a_ren;
    logic [31:0] a_rdata, a_rdp;
    logic [17:0] a_raddr;

    // instance B: four pixels per RAM line
    logic b_arvalid = 1'b0, b_arlast = 1'b0, b_rready = 1'b0;
    logic [17:0] b_araddr = '0;
    logic b_arready, b_rvalid, b_rlast, b_ren;
    logic [31:0] b_rdata;
    logic [127:0] b_rdp;
    logic [15:0] b_raddr;

    // instance C: read latency 3, FIFO depth 8
    logic c_arvalid = 1'b0, c_arlast = 1'b0, c_rready = 1'b0;
    logic [17:0] c_araddr = '0;
    logic c_arready, c_rvalid, c_rlast, c_ren;
    logic [31:0] c_rdata;
    logic [31:0] c_pipe [3];
    logic [17:0] c_raddr;

    internal_framebuffer_stream_reader dut_a (
        .clk(clk), .reset(reset),
        .arvalid(a_arvalid), .arready(a_arready), .arlast(a_arlast), .araddr(a_araddr),
        .rvalid(a_rvalid), .rready(a_rready), .rlast(a_rlast), .rdata(a_rdata),
        .readDataPort(a_rdp), .readAddrPort(a_raddr), .readEnablePort(a_ren)
    );

    internal_framebuffer_stream_reader #(.NUMBER_OF_PIXELS_PER_BEAT(4)) dut_b (
        .clk(clk), .reset(reset),
        .arvalid(b_arvalid), .arready(b_arready), .arlast(b_arlast), .araddr(b_araddr),
        .rvalid(b_rvalid), .rready(b_rready), .rlast(b_rlast), .rdata(b_rdata),
        .readDataPort(b_rdp), .readAddrPort(b_raddr), .readEnablePort(b_ren)
    );

    internal_framebuffer_stream_reader #(.MEM_READ_LATENCY(3), .FIFO_DEPTH(8)) dut_c (
        .clk(clk), .reset(reset),
        .arvalid(c_arvalid), .arready(c_arready), .arlast(c_arlast), .araddr(c_araddr),
        .rvalid(c_rvalid), .rready(c_rready), .rlast(c_rlast), .rdata(c_rdata),
        .readDataPort(c_pipe[2]), .readAddrPort(c_raddr), .readEnablePort(c_ren)
    );

    // framebuffer contents as a function of pixel address
    function automatic logic [31:0] hash_pix(input logic [17:0] a);
        return ({14'd0, a} * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] pix_a(input logic [17:0] a);
        return (a == 18'd5) ? 32'h1122_3344 : hash_pix(a);
    endfunction

    function automatic logic [31:0] pix_b(input logic [17:0] a);
        case (a)
            18'd8:   return 32'hAA;
            18'd9:   return 32'hBB;
            18'd10:  return 32'hCC;
            18'd11:  return 32'hDD;
            default: return hash_pix(a);
        endcase
    endfunction

    function automatic logic [127:0] line_b(input logic [15:0] l);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = pix_b({l, 2'(k)});
        return v;
    endfunction

    // RAM models: data valid MEM_READ_LATENCY cycles after the enable, garbage otherwise
    always @(posedge clk) begin
        a_rdp <= a_ren ? pix_a(a_raddr) : $urandom;
        b_rdp <= b_ren ? line_b(b_raddr) : {$urandom, $urandom, $urandom, $urandom};
        c_pipe[0] <= c_ren ? hash_pix(c_raddr) : $urandom;
        c_pipe[1] <= c_pipe[0];
        c_pipe[2] <= c_pipe[1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_arvalid = 1'b1; a_araddr = 18'd5; c_arvalid = 1'b1; b_arvalid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_vec++; if (a_arready !== 1'b0) begin n_err++; $display("FAIL reset_arready: got %b want 0", a_arready); end
        n_vec++; if (a_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b want 0", a_ren); end
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", a_rvalid); end
        n_vec++; if ({a_rlast, a_rdata} !== 33'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {a_rlast, a_rdata}); end
        n_vec++; if (c_arready !== 1'b0) begin n_err++; $display("FAIL reset_c_arready: got %b want 0", c_arready); end
        tick();
        reset = 1'b0; a_arvalid = 1'b0; b_arvalid = 1'b0; c_arvalid = 1'b0;
        @(negedge clk);
        n_vec++; if ({a_arready, b_arready, c_arready} !== 3'b111) begin n_err++; $display("FAIL post_reset_arready: got %b want 111", {a_arready, b_arready, c_arready}); end
        n_vec++; if ({a_rvalid, b_rvalid, c_rvalid} !== 3'b000) begin n_err++; $display("FAIL post_reset_rvalid: got %b want 000", {a_rvalid, b_rvalid, c_rvalid}); end
    endtask

    task automatic test_single_read();
        tick();
        a_arvalid = 1'b1; a_araddr = 18'd5; a_arlast = 1'b1; a_rready = 1'b1;
        @(negedge clk);
        n_vec++; if ({a_arready, a_ren, a_raddr} !== {2'b11, 18'd5}) begin n_err++; $display("FAIL single_issue: got rdy/en/addr %b/%b/%0d want 1/1/5", a_arready, a_ren, a_raddr); end
        tick();
        a_arvalid = 1'b0; a_arlast = 1'b0;
        @(negedge clk);
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL single_early: got rvalid %b want 0", a_rvalid); end
        tick();
        @(negedge clk);
        n_vec++; if ({a_rvalid, a_rlast, a_rdata} !== {2'b11, 32'h1122_3344}) begin n_err++; $display("FAIL single_data: got v/l/d %b/%b/%h want 1/1/11223344", a_rvalid, a_rlast, a_rdata); end
        tick();
        @(negedge clk);
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL single_after: got rvalid %b want 0", a_rvalid); end
    endtask

    task automatic test_streaming();
        logic [17:0] base;
        int issued, got, first, stalls, bubbles;
        logic [32:0] e;
        base = 18'($urandom_range(0, 262000));
        issued = 0; got = 0; first = -1; stalls = 0; bubbles = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            tick();
            a_arvalid = (issued < 16); a_araddr = base + 18'(issued); a_arlast = (issued == 15); a_rready = 1'b1;
            @(negedge clk);
            if (a_arvalid && a_arready) begin exp_q.push_back({a_arlast, pix_a(a_araddr)}); issued++; end
            else if (a_arvalid) stalls++;
            if (a_rvalid) begin
                if (first < 0) first = cyc;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
                n_vec++; if ({a_rlast, a_rdata} !== e) begin n_err++; $display("FAIL stream_beat%0d: got %h want %h", got, {a_rlast, a_rdata}, e); end
                got++;
            end else if (first >= 0) bubbles++;
        end
        tick();
        a_arvalid = 1'b0; a_arlast = 1'b0;
        n_vec++; if (got !== 16) begin n_err++; $display("FAIL stream_count: got %0d beats want 16", got); end
        n_vec++; if (stalls !== 0) begin n_err++; $display("FAIL stream_accept_stalls: got %0d want 0", stalls); end
        n_vec++; if (bubbles !== 0) begin n_err++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
        n_vec++; if (first !== 2) begin n_err++; $display("FAIL stream_latency: got first rvalid at %0d want 2", first); end
    endtask

    task automatic test_backpressure();
        int acc, got;
        logic held_ok;
        logic [32:0] hold, e;
        acc = 0; got = 0; held_ok = 1'b0; hold = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            a_arvalid = 1'b1; a_araddr = 18'($urandom); a_arlast = ($urandom_range(0, 2) == 0); a_rready = 1'b0;
            @(negedge clk);
            if (a_arvalid && a_arready) begin exp_q.push_back({a_arlast, pix_a(a_araddr)}); acc++; end
            if (a_rvalid) begin
                if (!held_ok) begin hold = {a_rlast, a_rdata}; held_ok = 1'b1; end
                else begin
                    n_vec++; if ({a_rlast, a_rdata} !== hold) begin n_err++; $display("FAIL bp_stable: got %h want %h", {a_rlast, a_rdata}, hold); end
                end
            end
        end
        n_vec++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        n_vec++; if (a_arready !== 1'b0) begin n_err++; $display("FAIL bp_arready_low: got %b want 0", a_arready); end
        n_vec++; if (hold !== exp_q[0]) begin n_err++; $display("FAIL bp_head: got %h want %h", hold, exp_q[0]); end
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            tick();
            a_arvalid = (acc < 8); a_araddr = 18'($urandom); a_arlast = ($urandom_range(0, 2) == 0); a_rready = 1'b1;
            @(negedge clk);
            if (cyc == 0) begin
                n_vec++; if (a_arready !== 1'b0) begin n_err++; $display("FAIL bp_pop_cycle_arready: got %b want 0", a_arready); end
            end
            if (cyc == 1) begin
                n_vec++; if (a_arready !== 1'b1) begin n_err++; $display("FAIL bp_reopen_arready: got %b want 1", a_arready); end
            end
            if (a_arvalid && a_arready) begin exp_q.push_back({a_arlast, pix_a(a_araddr)}); acc++; end
            if (a_rvalid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
                n_vec++; if ({a_rlast, a_rdata} !== e) begin n_err++; $display("FAIL bp_drain%0d: got %h want %h", got, {a_rlast, a_rdata}, e); end
                got++;
            end
        end
        tick();
        a_arvalid = 1'b0; a_arlast = 1'b0;
        n_vec++; if (got !== 8 || exp_q.size() != 0) begin n_err++; $display("FAIL bp_total: got %0d beats, %0d left, want 8 and 0", got, exp_q.size()); end
    endtask

    task automatic test_lane_select();
        logic [17:0] addrs [16];
        int issued, got;
        logic [32:0] e;
        for (int i = 0; i < 16; i++) addrs[i] = (i < 4) ? 18'(8 + i) : 18'($urandom);
        issued = 0; got = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            tick();
            b_arvalid = (issued < 16) && (issued < 4 || $urandom_range(0, 3) != 0);
            b_araddr = addrs[issued % 16]; b_arlast = (issued == 3) || (issued == 15);
            b_rready = (got < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_arvalid && b_arready) begin
                n_vec++; if ({b_ren, b_raddr} !== {1'b1, b_araddr[17:2]}) begin n_err++; $display("FAIL lane_line_addr%0d: got %b/%0d want 1/%0d", issued, b_ren, b_raddr, b_araddr[17:2]); end
                exp_q.push_back({b_arlast, pix_b(b_araddr)});
                issued++;
            end
            if (b_rvalid && b_rready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
                n_vec++; if ({b_rlast, b_rdata} !== e) begin n_err++; $display("FAIL lane_pixel%0d: got %h want %h", got, {b_rlast, b_rdata}, e); end
                got++;
            end
        end
        tick();
        b_arvalid = 1'b0; b_rready = 1'b0;
        n_vec++; if (got !== 16) begin n_err++; $display("FAIL lane_count: got %0d want 16", got); end
    endtask

    task automatic test_latency3();
        logic [17:0] a0;
        int issued, got;
        logic [32:0] e;
        a0 = 18'($urandom);
        tick();
        c_arvalid = 1'b1; c_araddr = a0; c_arlast = 1'b1; c_rready = 1'b1;
        @(negedge clk);
        n_vec++; if (c_arready !== 1'b1) begin n_err++; $display("FAIL lat3_accept: got %b want 1", c_arready); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            c_arvalid = 1'b0; c_arlast = 1'b0;
            @(negedge clk);
            if (k < 4) begin
                n_vec++; if (c_rvalid !== 1'b0) begin n_err++; $display("FAIL lat3_early%0d: got rvalid %b want 0", k, c_rvalid); end
            end else begin
                n_vec++; if ({c_rvalid, c_rlast, c_rdata} !== {2'b11, hash_pix(a0)}) begin n_err++; $display("FAIL lat3_first: got %b/%b/%h want 1/1/%h", c_rvalid, c_rlast, c_rdata, hash_pix(a0)); end
            end
        end
        issued = 0; got = 0;
        exp_c.delete();
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            tick();
            c_arvalid = (issued < 40) && ($urandom_range(0, 3) != 0);
            c_araddr = 18'($urandom); c_arlast = ($urandom_range(0, 4) == 0);
            c_rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c_arvalid && c_arready) begin exp_c.push_back({c_arlast, hash_pix(c_araddr)}); issued++; end
            if (c_rvalid && c_rready) begin
                e = (exp_c.size() != 0) ? exp_c.pop_front() : 33'bx;
                n_vec++; if ({c_rlast, c_rdata} !== e) begin n_err++; $display("FAIL lat3_beat%0d: got %h want %h", got, {c_rlast, c_rdata}, e); end
                got++;
            end
        end
        tick();
        c_arvalid = 1'b0; c_rready = 1'b0;
        n_vec++; if (got !== 40 || exp_c.size() != 0) begin n_err++; $display("FAIL lat3_total: got %0d beats, %0d left, want 40 and 0", got, exp_c.size()); end
    endtask

    task automatic test_reset_midflight();
        int a_acc, c_acc, stale;
        logic [17:0] cn;
        a_acc = 0; c_acc = 0; stale = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            a_arvalid = (a_acc < 2); a_araddr = 18'($urandom); a_rready = 1'b0;
            c_arvalid = (c_acc < 5); c_araddr = 18'($urandom); c_rready = 1'b0;
            @(negedge clk);
            if (a_arvalid && a_arready) a_acc++;
            if (c_arvalid && c_arready) c_acc++;
        end
        n_vec++; if (c_acc !== 5 || a_acc !== 2) begin n_err++; $display("FAIL mid_preload: got %0d/%0d accepts want 5/2", c_acc, a_acc); end
        tick();
        reset = 1'b1; a_arvalid = 1'b0; c_arvalid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if ({a_rvalid, c_rvalid} !== 2'b00) begin n_err++; $display("FAIL mid_rvalid: got %b want 00", {a_rvalid, c_rvalid}); end
        n_vec++; if ({a_arready, c_arready} !== 2'b11) begin n_err++; $display("FAIL mid_arready: got %b want 11", {a_arready, c_arready}); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            a_rready = 1'b1; c_rready = 1'b1;
            @(negedge clk);
            if (a_rvalid || c_rvalid) stale++;
        end
        n_vec++; if (stale !== 0) begin n_err++; $display("FAIL mid_stale: got %0d stale cycles want 0", stale); end
        cn = 18'($urandom);
        tick();
        a_arvalid = 1'b1; a_araddr = 18'd5; a_arlast = 1'b0;
        c_arvalid = 1'b1; c_araddr = cn; c_arlast = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            tick();
            a_arvalid = 1'b0; c_arvalid = 1'b0;
            @(negedge clk);
            if (k == 2) begin
                n_vec++; if ({a_rvalid, a_rlast, a_rdata} !== {2'b10, 32'h1122_3344}) begin n_err++; $display("FAIL mid_new_a: got %b/%b/%h want 1/0/11223344", a_rvalid, a_rlast, a_rdata); end
            end
            if (k == 4) begin
                n_vec++; if ({c_rvalid, c_rlast, c_rdata} !== {2'b11, hash_pix(cn)}) begin n_err++; $display("FAIL mid_new_c: got %b/%b/%h want 1/1/%h", c_rvalid, c_rlast, c_rdata, hash_pix(cn)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_streaming();
        test_backpressure();
        test_lane_select();
        test_latency3();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
